// File: rtl/glm_dot.sv
// glm_dot: forward half of the GLM SGD datapath.
// Streams sample lines against model lines from BRAM, accumulates an fp32 dot
// product, subtracts one label, scales by the step and writes one gradient scalar.
// The fp32 units handle normal numbers only: denormals flush to zero, results
// truncate, and there is no NaN/inf propagation beyond saturating to inf.
module glm_dot #(
  parameter int VALUES_PER_LINE = 16,
  parameter int LINE_W          = 32 * VALUES_PER_LINE
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              op_start,
  output logic              op_done,
  input  logic [4:0][31:0]  regs,
  output logic              samples_re,
  input  logic              samples_rvalid,
  input  logic [LINE_W-1:0] samples_rdata,
  input  logic              samples_empty,
  output logic              labels_re,
  input  logic              labels_rvalid,
  input  logic [31:0]       labels_rdata,
  input  logic              labels_empty,
  output logic              model_re,
  output logic [15:0]       model_raddr,
  input  logic              model_rvalid,
  input  logic [LINE_W-1:0] model_rdata,
  output logic              fwd_we,
  output logic [LINE_W-1:0] fwd_wdata,
  input  logic              fwd_almostfull,
  output logic              grad_we,
  output logic [31:0]       grad_wdata,
  input  logic              grad_almostfull
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAIN  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_LABEL = 3'd3;
  localparam logic [2:0] S_GRAD  = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  logic [2:0]  state;
  logic [31:0] step_q;
  logic [15:0] off_q;
  logic [15:0] len_q;
  logic        fwd_q;
  logic [15:0] req;
  logic [15:0] acc_cnt;
  logic [31:0] dot;
  logic [31:0] prod_q;
  logic        prod_v;
  logic [31:0] label_q;
  logic        label_req;
  logic [31:0] diff_q;
  logic        gsub;
  logic [31:0] line_sum;
  logic        active;

  // Register words 0 and 1 and the upper bits of word 4 carry nothing for this stage.
  logic unused_regs;
  assign unused_regs = ^{regs[0], regs[1], regs[4][31:1]};

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    int          e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      p = p >> 1;
      e = e + 1;
    end
    if (e <= 0) return {s, 31'd0};
    if (e >= 255) return {s, 8'hff, 23'd0};
    return {s, e[7:0], p[45:23]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [27:0] mx, my, s;
    int          ex, ey, d;
    if (a[30:0] < b[30:0]) begin
      x = b;
      y = a;
    end else begin
      x = a;
      y = b;
    end
    if (y[30:23] == 8'd0) return (x[30:23] == 8'd0) ? {x[31] & y[31], 31'd0} : x;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    d  = ex - ey;
    mx = {1'b0, 1'b1, x[22:0], 3'b000};
    my = {1'b0, 1'b1, y[22:0], 3'b000};
    my = (d > 27) ? 28'd0 : (my >> d);
    s  = (x[31] == y[31]) ? (mx + my) : (mx - my);
    if (s == 28'd0) return 32'd0;
    if (s[27]) begin
      s  = s >> 1;
      ex = ex + 1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!s[26]) begin
        s  = s << 1;
        ex = ex - 1;
      end
    end
    if (ex <= 0) return {x[31], 31'd0};
    if (ex >= 255) return {x[31], 8'hff, 23'd0};
    return {x[31], ex[7:0], s[25:3]};
  endfunction

  // Lane products reduced pairwise so the tree depth grows with log2 of the lane count.
  function automatic logic [31:0] line_dot(input logic [LINE_W-1:0] sv, input logic [LINE_W-1:0] mv);
    logic [31:0] p [VALUES_PER_LINE];
    for (int i = 0; i < VALUES_PER_LINE; i++) p[i] = fp_mul(sv[32*i +: 32], mv[32*i +: 32]);
    for (int w = VALUES_PER_LINE / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) p[i] = fp_add(p[2*i], p[2*i+1]);
    end
    return p[0];
  endfunction

  // Combinational line scalar from the aligned sample/model read data.
  always_comb begin
    line_sum = line_dot(samples_rdata, model_rdata);
  end

  assign active = (state == S_MAIN) || (state == S_DRAIN);

  // Control FSM plus the two-stage line-product/accumulate pipeline; every strobe is a
  // one-cycle registered pulse. A new read waits until the previous re has popped the
  // FIFO, since empty cannot reflect that pop in the cycle the re is still visible.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      op_done     <= 1'b0;
      samples_re  <= 1'b0;
      labels_re   <= 1'b0;
      model_re    <= 1'b0;
      model_raddr <= 16'd0;
      fwd_we      <= 1'b0;
      fwd_wdata   <= '0;
      grad_we     <= 1'b0;
      grad_wdata  <= 32'd0;
      step_q      <= 32'd0;
      off_q       <= 16'd0;
      len_q       <= 16'd0;
      fwd_q       <= 1'b0;
      req         <= 16'd0;
      acc_cnt     <= 16'd0;
      dot         <= 32'd0;
      prod_q      <= 32'd0;
      prod_v      <= 1'b0;
      label_q     <= 32'd0;
      label_req   <= 1'b0;
      diff_q      <= 32'd0;
      gsub        <= 1'b0;
    end else begin
      op_done    <= 1'b0;
      samples_re <= 1'b0;
      labels_re  <= 1'b0;
      model_re   <= 1'b0;
      fwd_we     <= 1'b0;
      grad_we    <= 1'b0;
      prod_v     <= 1'b0;

      if (active && samples_rvalid && model_rvalid) begin
        prod_q <= line_sum;
        prod_v <= 1'b1;
      end
      if (active && prod_v) begin
        dot     <= fp_add(dot, prod_q);
        acc_cnt <= acc_cnt + 16'd1;
      end
      if (active && fwd_q && samples_rvalid) begin
        fwd_we    <= 1'b1;
        fwd_wdata <= samples_rdata;
      end

      case (state)
        S_IDLE: begin
          if (op_start) begin
            step_q    <= regs[2];
            off_q     <= regs[3][15:0];
            len_q     <= regs[3][31:16];
            fwd_q     <= regs[4][0];
            req       <= 16'd0;
            acc_cnt   <= 16'd0;
            dot       <= 32'd0;
            label_req <= 1'b0;
            state     <= S_MAIN;
          end
        end
        S_MAIN: begin
          if (req == len_q) begin
            state <= S_DRAIN;
          end else if (!samples_empty && !samples_re && !(fwd_q && fwd_almostfull)) begin
            samples_re  <= 1'b1;
            model_re    <= 1'b1;
            model_raddr <= off_q + req;
            req         <= req + 16'd1;
          end
        end
        S_DRAIN: begin
          if (acc_cnt == len_q) state <= S_LABEL;
        end
        S_LABEL: begin
          if (!label_req && !labels_empty) begin
            labels_re <= 1'b1;
            label_req <= 1'b1;
          end
          if (label_req && labels_rvalid) begin
            label_q <= labels_rdata;
            gsub    <= 1'b0;
            state   <= S_GRAD;
          end
        end
        S_GRAD: begin
          if (!gsub) begin
            diff_q <= fp_add(dot, {~label_q[31], label_q[30:0]});
            gsub   <= 1'b1;
          end else begin
            grad_wdata <= fp_mul(step_q, diff_q);
            state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (!grad_almostfull) begin
            grad_we <= 1'b1;
            state   <= S_FIN;
          end
        end
        S_FIN: begin
          op_done <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
